// File: rtl/sram_arbiter_pkg.sv
// Shared types and sizing constants for the SRAM arbiter and its tag pipeline.
package sram_arbiter_pkg;

    localparam int SRAM_READ_LATENCY = 2;
    localparam int SRAM_DEPTH_WORDS  = 256;
    localparam int SRAM_ADDR_WIDTH   = 8;

    typedef enum logic {
        ARB_IMEM = 1'b0,
        ARB_DMEM = 1'b1
    } arb_owner_t;

    typedef struct packed {
        logic       valid;
        arb_owner_t owner;
        logic       err;
    } arb_tag_t;

endpackage

// File: rtl/sram_tag_pipe.sv
// LAT-deep shift register of read tags; shifts every cycle, cleared by reset.
module sram_tag_pipe
    import sram_arbiter_pkg::*;
#(
    parameter int LAT = SRAM_READ_LATENCY
) (
    input  logic     CLK,
    input  logic     nRST,
    input  arb_tag_t tag_in,
    output arb_tag_t tag_out
);

    arb_tag_t stage_q [LAT];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < LAT; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= tag_in;
            for (int i = 1; i < LAT; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign tag_out = stage_q[LAT-1];

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates imem/dmem onto one single-port SRAM and steers read returns by tag.
// Define SRAM_ARB_RR_EN for round-robin arbitration instead of fixed dmem priority.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int LAT   = SRAM_READ_LATENCY,
    parameter int AW    = SRAM_ADDR_WIDTH,
    parameter int DEPTH = SRAM_DEPTH_WORDS
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          imem_ren,
    input  logic [31:0]   imem_addr,
    output logic          imem_gnt,
    output logic          imem_rvalid,
    output logic [31:0]   imem_rdata,
    output logic          imem_err,
    input  logic          dmem_ren,
    input  logic          dmem_wen,
    input  logic [31:0]   dmem_addr,
    input  logic [31:0]   dmem_wdata,
    output logic          dmem_gnt,
    output logic          dmem_rvalid,
    output logic [31:0]   dmem_rdata,
    output logic          dmem_err,
    output logic          sram_en,
    output logic          sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [31:0]   sram_din,
    input  logic [31:0]   sram_dout
);

    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

    logic        imem_req, dmem_req, dmem_wins, gnt_any, is_store, in_range;
    logic [31:0] sel_addr;
    arb_tag_t    tag_in, tag_out;
    logic        unused_addr_bits;

`ifdef SRAM_ARB_RR_EN
    arb_owner_t last_owner_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last_owner_q <= ARB_IMEM;
        end else if (gnt_any) begin
            last_owner_q <= dmem_wins ? ARB_DMEM : ARB_IMEM;
        end
    end
`endif

    always_comb begin
        // Gating with nRST keeps every grant and the SRAM enable low during reset.
        imem_req = imem_ren && nRST;
        dmem_req = (dmem_ren || dmem_wen) && nRST;
`ifdef SRAM_ARB_RR_EN
        dmem_wins = dmem_req && (!imem_req || (last_owner_q == ARB_IMEM));
`else
        dmem_wins = dmem_req;
`endif
        dmem_gnt = dmem_wins;
        imem_gnt = imem_req && !dmem_wins;
        gnt_any  = imem_gnt || dmem_gnt;
        sel_addr = dmem_wins ? dmem_addr : imem_addr;
        is_store = dmem_wins && dmem_wen;
        in_range = sel_addr[31:2] < DEPTH_W;

        sram_en   = gnt_any && in_range;
        sram_we   = sram_en && is_store;
        sram_addr = sel_addr[AW+1:2];
        sram_din  = dmem_wdata;

        tag_in.valid = gnt_any && !is_store;
        tag_in.owner = dmem_wins ? ARB_DMEM : ARB_IMEM;
        tag_in.err   = gnt_any && !is_store && !in_range;
    end

    assign unused_addr_bits = ^sel_addr[1:0];

    sram_tag_pipe #(.LAT(LAT)) u_tag_pipe (
        .CLK     (CLK),
        .nRST    (nRST),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    always_comb begin
        imem_rvalid = tag_out.valid && (tag_out.owner == ARB_IMEM);
        dmem_rvalid = tag_out.valid && (tag_out.owner == ARB_DMEM);
        imem_err    = imem_rvalid && tag_out.err;
        // Store range errors are reported at grant, load errors on return.
        dmem_err    = (dmem_rvalid && tag_out.err) || (is_store && !in_range);
        imem_rdata  = (imem_rvalid && !tag_out.err) ? sram_dout : 32'h0;
        dmem_rdata  = (dmem_rvalid && !tag_out.err) ? sram_dout : 32'h0;
    end

    a_no_ren_wen: assert property (@(posedge CLK) disable iff (!nRST) !(dmem_ren && dmem_wen));

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural two-cycle-latency SRAM.
module tb_sram_arbiter;
    import sram_arbiter_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imem_ren, imem_gnt, imem_rvalid, imem_err;
    logic [31:0] imem_addr, imem_rdata;
    logic        dmem_ren, dmem_wen, dmem_gnt, dmem_rvalid, dmem_err;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        sram_en, sram_we;
    logic [7:0]  sram_addr;
    logic [31:0] sram_din, sram_dout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    sram_arbiter dut (
        .CLK(CLK), .nRST(nRST),
        .imem_ren(imem_ren), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
        .dmem_ren(dmem_ren), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .dmem_err(dmem_err),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout)
    );

    // SRAM model: word i preloaded with 0xA5000000 + i, read data two edges after enable.
    logic [31:0] mem [256];
    logic [31:0] rd1, rd2;
    logic        init_done = 1'b0;

    always @(posedge CLK) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 + 32'(i);
            init_done <= 1'b1;
        end else if (sram_en && sram_we) begin
            mem[sram_addr] <= sram_din;
        end
        if (sram_en && !sram_we) rd1 <= mem[sram_addr];
        rd2 <= rd1;
    end
    assign sram_dout = rd2;

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        imem_ren = 0; dmem_ren = 0; dmem_wen = 0;
    endtask

    task automatic test_reset();
        nRST = 0; idle_inputs();
        imem_addr = 0; dmem_addr = 0; dmem_wdata = 0;
        repeat (3) next_cycle();
        imem_ren = 1; imem_addr = 32'h10;
        #1;
        n_checks++; if (imem_gnt !== 1'b0) begin n_errors++; $display("FAIL rst_imem_gnt: got %b exp 0", imem_gnt); end
        n_checks++; if (dmem_gnt !== 1'b0) begin n_errors++; $display("FAIL rst_dmem_gnt: got %b exp 0", dmem_gnt); end
        n_checks++; if (sram_en !== 1'b0 || sram_we !== 1'b0) begin n_errors++; $display("FAIL rst_sram_en_we: got %b%b exp 00", sram_en, sram_we); end
        n_checks++; if ({imem_rvalid, dmem_rvalid, imem_err, dmem_err} !== 4'b0) begin n_errors++; $display("FAIL rst_rvalid_err: got %b exp 0000", {imem_rvalid, dmem_rvalid, imem_err, dmem_err}); end
        n_checks++; if (imem_rdata !== 32'h0 || dmem_rdata !== 32'h0) begin n_errors++; $display("FAIL rst_rdata: got %h %h exp 0 0", imem_rdata, dmem_rdata); end
        imem_ren = 0;
        next_cycle();
        nRST = 1;
    endtask

    task automatic test_single_fetch();
        next_cycle();
        imem_ren = 1; imem_addr = 32'h10;
        #1;
        n_checks++; if (imem_gnt !== 1'b1 || dmem_gnt !== 1'b0) begin n_errors++; $display("FAIL fetch_gnt: got i%b d%b exp i1 d0", imem_gnt, dmem_gnt); end
        n_checks++; if (sram_en !== 1'b1 || sram_we !== 1'b0) begin n_errors++; $display("FAIL fetch_en_we: got %b%b exp 10", sram_en, sram_we); end
        n_checks++; if (sram_addr !== 8'd4) begin n_errors++; $display("FAIL fetch_addr: got %0d exp 4", sram_addr); end
        next_cycle(); imem_ren = 0; #1;
        n_checks++; if (imem_rvalid !== 1'b0) begin n_errors++; $display("FAIL fetch_early_rvalid: got %b exp 0", imem_rvalid); end
        next_cycle(); #1;
        n_checks++; if (imem_rvalid !== 1'b1 || imem_err !== 1'b0) begin n_errors++; $display("FAIL fetch_rvalid: got v%b e%b exp v1 e0", imem_rvalid, imem_err); end
        n_checks++; if (imem_rdata !== 32'hA500_0004) begin n_errors++; $display("FAIL fetch_rdata: got %h exp a5000004", imem_rdata); end
        n_checks++; if (dmem_rvalid !== 1'b0 || dmem_rdata !== 32'h0) begin n_errors++; $display("FAIL fetch_dmem_quiet: got v%b %h exp v0 0", dmem_rvalid, dmem_rdata); end
        next_cycle(); #1;
        n_checks++; if (imem_rvalid !== 1'b0) begin n_errors++; $display("FAIL fetch_late_rvalid: got %b exp 0", imem_rvalid); end
    endtask

    task automatic test_collision();
        next_cycle();
        imem_ren = 1; imem_addr = 32'h0; dmem_ren = 1; dmem_addr = 32'h8;
        #1;
        n_checks++; if (dmem_gnt !== 1'b1 || imem_gnt !== 1'b0) begin n_errors++; $display("FAIL coll_first: got d%b i%b exp d1 i0", dmem_gnt, imem_gnt); end
        n_checks++; if (sram_addr !== 8'd2) begin n_errors++; $display("FAIL coll_first_addr: got %0d exp 2", sram_addr); end
        next_cycle(); dmem_ren = 0; #1;
        n_checks++; if (imem_gnt !== 1'b1 || sram_addr !== 8'd0) begin n_errors++; $display("FAIL coll_second: got i%b addr %0d exp i1 addr 0", imem_gnt, sram_addr); end
        next_cycle(); imem_ren = 0; #1;
        n_checks++; if (dmem_rvalid !== 1'b1 || dmem_rdata !== 32'hA500_0002) begin n_errors++; $display("FAIL coll_dmem_ret: got v%b %h exp v1 a5000002", dmem_rvalid, dmem_rdata); end
        n_checks++; if (imem_rvalid !== 1'b0 || imem_rdata !== 32'h0) begin n_errors++; $display("FAIL coll_imem_quiet: got v%b %h exp v0 0", imem_rvalid, imem_rdata); end
        next_cycle(); #1;
        n_checks++; if (imem_rvalid !== 1'b1 || imem_rdata !== 32'hA500_0000) begin n_errors++; $display("FAIL coll_imem_ret: got v%b %h exp v1 a5000000", imem_rvalid, imem_rdata); end
        n_checks++; if (dmem_rvalid !== 1'b0 || dmem_rdata !== 32'h0) begin n_errors++; $display("FAIL coll_dmem_quiet: got v%b %h exp v0 0", dmem_rvalid, dmem_rdata); end
    endtask

    task automatic test_back_to_back();
        next_cycle();
        dmem_wen = 1; dmem_addr = 32'h20; dmem_wdata = 32'hDEAD_BEEF;
        #1;
        n_checks++; if (dmem_gnt !== 1'b1 || dmem_err !== 1'b0) begin n_errors++; $display("FAIL st_gnt: got g%b e%b exp g1 e0", dmem_gnt, dmem_err); end
        n_checks++; if ({sram_en, sram_we} !== 2'b11 || sram_addr !== 8'd8 || sram_din !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL st_sram: got %b%b %0d %h exp 11 8 deadbeef", sram_en, sram_we, sram_addr, sram_din); end
        next_cycle(); dmem_wen = 0; dmem_ren = 1; #1;
        n_checks++; if (dmem_gnt !== 1'b1 || sram_we !== 1'b0) begin n_errors++; $display("FAIL ld_gnt: got g%b we%b exp g1 we0", dmem_gnt, sram_we); end
        next_cycle(); dmem_ren = 0; #1;
        n_checks++; if (dmem_rvalid !== 1'b0) begin n_errors++; $display("FAIL st_no_rvalid: got %b exp 0", dmem_rvalid); end
        next_cycle(); #1;
        n_checks++; if (dmem_rvalid !== 1'b1 || dmem_rdata !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL ld_after_st: got v%b %h exp v1 deadbeef", dmem_rvalid, dmem_rdata); end
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            dmem_ren = (i < 4); dmem_addr = 32'h10 + 32'(4 * i);
            #1;
            if (i < 4) begin
                n_checks++; if (dmem_gnt !== 1'b1) begin n_errors++; $display("FAIL stream_gnt[%0d]: got %b exp 1", i, dmem_gnt); end
            end
            if (i >= 2) begin
                n_checks++; if (dmem_rvalid !== 1'b1 || dmem_rdata !== 32'hA500_0004 + 32'(i - 2)) begin n_errors++; $display("FAIL stream_ret[%0d]: got v%b %h exp v1 %h", i, dmem_rvalid, dmem_rdata, 32'hA500_0004 + 32'(i - 2)); end
            end
        end
        dmem_ren = 0;
    endtask

    task automatic test_out_of_range();
        next_cycle();
        dmem_ren = 1; dmem_addr = 32'h3FC;
        #1;
        n_checks++; if (sram_en !== 1'b1 || sram_addr !== 8'd255) begin n_errors++; $display("FAIL last_word: got en%b %0d exp en1 255", sram_en, sram_addr); end
        next_cycle(); dmem_addr = 32'h400; #1;
        n_checks++; if (dmem_gnt !== 1'b1 || sram_en !== 1'b0 || dmem_err !== 1'b0) begin n_errors++; $display("FAIL oor_ld_gnt: got g%b en%b e%b exp g1 en0 e0", dmem_gnt, sram_en, dmem_err); end
        next_cycle(); dmem_ren = 0; #1;
        n_checks++; if (dmem_rvalid !== 1'b1 || dmem_err !== 1'b0 || dmem_rdata !== 32'hA500_00FF) begin n_errors++; $display("FAIL last_word_ret: got v%b e%b %h exp v1 e0 a50000ff", dmem_rvalid, dmem_err, dmem_rdata); end
        next_cycle(); #1;
        n_checks++; if (dmem_rvalid !== 1'b1 || dmem_err !== 1'b1 || dmem_rdata !== 32'h0) begin n_errors++; $display("FAIL oor_ld_ret: got v%b e%b %h exp v1 e1 0", dmem_rvalid, dmem_err, dmem_rdata); end
        next_cycle();
        dmem_wen = 1; dmem_addr = 32'h400; dmem_wdata = 32'h1234_5678;
        #1;
        n_checks++; if (dmem_gnt !== 1'b1 || dmem_err !== 1'b1 || sram_en !== 1'b0 || sram_we !== 1'b0) begin n_errors++; $display("FAIL oor_st: got g%b e%b en%b we%b exp g1 e1 en0 we0", dmem_gnt, dmem_err, sram_en, sram_we); end
        next_cycle(); dmem_wen = 0; dmem_ren = 1; dmem_addr = 32'h0; #1;
        next_cycle(); dmem_ren = 0; #1;
        n_checks++; if (dmem_err !== 1'b0) begin n_errors++; $display("FAIL oor_st_err_clear: got %b exp 0", dmem_err); end
        next_cycle(); #1;
        n_checks++; if (dmem_rvalid !== 1'b1 || dmem_rdata !== 32'hA500_0000) begin n_errors++; $display("FAIL oor_st_nowrite: got v%b %h exp v1 a5000000", dmem_rvalid, dmem_rdata); end
    endtask

    task automatic test_reset_midflight();
        next_cycle();
        imem_ren = 1; imem_addr = 32'h4;
        next_cycle();
        imem_ren = 0; dmem_ren = 1; dmem_addr = 32'hC;
        next_cycle();
        dmem_ren = 0; nRST = 0;
        #1;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (imem_rvalid !== 1'b0 || dmem_rvalid !== 1'b0) begin n_errors++; $display("FAIL flush[%0d]: got i%b d%b exp 0 0", i, imem_rvalid, dmem_rvalid); end
            next_cycle();
            if (i == 1) nRST = 1;
            #1;
        end
        imem_ren = 1; imem_addr = 32'h10;
        #1;
        n_checks++; if (imem_gnt !== 1'b1) begin n_errors++; $display("FAIL post_rst_gnt: got %b exp 1", imem_gnt); end
        next_cycle(); imem_ren = 0;
        next_cycle(); #1;
        n_checks++; if (imem_rvalid !== 1'b1 || imem_rdata !== 32'hA500_0004) begin n_errors++; $display("FAIL post_rst_ret: got v%b %h exp v1 a5000004", imem_rvalid, imem_rdata); end
    endtask

    task automatic test_starvation();
        logic exp_imem;
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            dmem_ren = 1; dmem_addr = 32'h0; imem_ren = 1; imem_addr = 32'h8;
            #1;
`ifdef SRAM_ARB_RR_EN
            exp_imem = (i % 2 == 1);
`else
            exp_imem = 1'b0;
`endif
            n_checks++; if (imem_gnt !== exp_imem || dmem_gnt !== !exp_imem) begin n_errors++; $display("FAIL starve[%0d]: got i%b d%b exp i%b d%b", i, imem_gnt, dmem_gnt, exp_imem, !exp_imem); end
        end
        idle_inputs();
        repeat (3) next_cycle();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_collision();
        test_back_to_back();
        test_out_of_range();
        test_reset_midflight();
        test_starvation();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
